// File: rtl/if_fetch_buf_pkg.sv
// Shared constants for the instruction-fetch stage: default bus widths and the
// sequential PC step.
package if_fetch_buf_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int INST_W_DEF = 32;
  localparam int PC_INC     = 4;

endpackage

// File: rtl/if_fetch_buf_fifo.sv
// Synchronous DEPTH-entry FIFO holding fetched {pc, inst} pairs; head is
// combinational from the read pointer, clear empties it in one edge.
module if_fetch_buf_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     wdata_i,
  output logic [CNT_W-1:0] count_o,
  output logic [W-1:0]     head_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: defaults first, so no path through this block leaves a signal unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // NOTE: non-blocking assignments for all state, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count qualifies every read of it.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assert property (@(posedge clk) disable iff (!rst)
    !(push_i && !pop_i && !clear_i && (count_q == CNT_W'(DEPTH))))
    else $error("if_fetch_buf_fifo: push while full");

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction-fetch stage with prefetch queue, credit-based ROM issue and
// redirect flush. Define IF_BYPASS_EN to forward a ROM response straight to decode when the queue is empty.
module if_fetch_buf
  import if_fetch_buf_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INST_W   = INST_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_ce_o,
  input  logic [INST_W-1:0] rom_data_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + INST_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  fifo_count;
  logic [ENT_W-1:0]  fifo_head;
  logic              fifo_empty;
  logic              bypass_sel;
  logic              pop;
  logic              push;
  logic              fifo_pop;
  logic              issue;
  logic [CNT_W:0]    credit_used;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
  assign fifo_empty           = (fifo_count == '0);

`ifdef IF_BYPASS_EN
  assign bypass_sel = fifo_empty & inflight_q;
`else
  assign bypass_sel = 1'b0;
`endif

  assign id_valid_o = rst & (~fifo_empty | bypass_sel);
  assign pop        = id_valid_o & id_ready_i & ~redirect_i;
  assign fifo_pop   = pop & ~fifo_empty;
  // A bypassed response that decode takes this cycle never enters the queue.
  assign push       = rst & inflight_q & ~redirect_i & ~(bypass_sel & pop);

  // Queued entries plus the outstanding request, less what leaves this cycle.
  assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign issue       = rst & ~redirect_i & (credit_used < (CNT_W+1)'(DEPTH));

  assign rom_ce_o   = issue;
  assign rom_addr_o = rst ? fetch_pc_q : RESET_PC;

  always_comb begin
    id_pc_o   = '0;
    id_inst_o = '0;
    if (id_valid_o) begin
      if (bypass_sel) {id_pc_o, id_inst_o} = {inflight_pc_q, rom_data_i};
      else            {id_pc_o, id_inst_o} = fifo_head;
    end
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (redirect_i) begin
      fetch_pc_d = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + ADDR_W'(PC_INC);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  if_fetch_buf_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (~rst | redirect_i),
    .push_i  (push),
    .pop_i   (fifo_pop),
    .wdata_i ({inflight_pc_q, rom_data_i}),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

endmodule

// File: tb/tb_if_fetch_buf.sv
// Scoreboard bench for if_fetch_buf: a program-order model predicts ROM requests
// and the decode stream; directed scenarios followed by randomized traffic.
module tb_if_fetch_buf;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] ROM_KEY  = 32'hA5A5_0000;
`ifdef IF_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic [31:0] rom_data_i = '0;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [31:0] next_fetch = RESET_PC;
  logic        exp_valid;
  logic        exp_ce;

  if_fetch_buf #(
    .ADDR_W   (32),
    .INST_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_addr_o    (rom_addr_o),
    .rom_ce_o      (rom_ce_o),
    .rom_data_i    (rom_data_i),
    .id_pc_o       (id_pc_o),
    .id_inst_o     (id_inst_o),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM: data for a requested address appears the following cycle.
  always @(posedge clk) begin
    if (rom_ce_o) rom_data_i <= rom_addr_o ^ ROM_KEY;
    else          rom_data_i <= $urandom();
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    rst           = r;
    id_ready_i    = rdy;
    redirect_i    = rd;
    redirect_pc_i = rpc;
  endtask

  // Monitor: decode-side outputs against the head of the expected stream.
  always @(negedge clk) begin
    if (!rst) begin
      check("rst_id_valid", id_valid_o, 1'b0);
      check("rst_id_pc", id_pc_o, 32'h0);
      check("rst_id_inst", id_inst_o, 32'h0);
    end else begin
      exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc + LAT <= cyc);
      check("id_valid", id_valid_o, exp_valid);
      if (exp_valid) begin
        check("id_pc", id_pc_o, exp_q[0].pc);
        check("id_inst", id_inst_o, exp_q[0].pc ^ ROM_KEY);
      end else begin
        check("idle_id_pc", id_pc_o, 32'h0);
        check("idle_id_inst", id_inst_o, 32'h0);
      end
      if (exp_valid && id_ready_i && !redirect_i) void'(exp_q.pop_front());
    end
  end

  // Issue model: at most DEPTH fetches outstanding (queued or in flight), in program order.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      check("rst_rom_ce", rom_ce_o, 1'b0);
      check("rst_rom_addr", rom_addr_o, RESET_PC);
      exp_q.delete();
      next_fetch = RESET_PC;
    end else begin
      exp_ce = !redirect_i && (exp_q.size() < DEPTH);
      check("rom_ce", rom_ce_o, exp_ce);
      if (exp_ce) check("rom_addr", rom_addr_o, next_fetch);
      if (redirect_i) begin
        exp_q.delete();
        next_fetch = redirect_pc_i & ~32'h3;
      end else if (exp_ce) begin
        exp_q.push_back('{pc: next_fetch, cyc: cyc});
        next_fetch = next_fetch + 32'd4;
      end
    end
  end

  initial begin
    logic [31:0] rpc;

    // Straight-line stream with decode always ready.
    repeat (3)  drive(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (20) drive(1'b1, 1'b1, 1'b0, 32'h0);

    // Decode stalled: queue fills, issue stops, then drains in order.
    repeat (2)  drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (10) drive(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (10) drive(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect to an unaligned target in cycle 6 with the queue partially full.
    repeat (2)  drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) drive(1'b1, (i % 3) == 0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    repeat (8)  drive(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect during steady streaming: coincides with a pop and an arriving response.
    repeat (6)  drive(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    repeat (6)  drive(1'b1, 1'b1, 1'b0, 32'h0);

    // Fetch PC wrap at the top of the address space.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (8)  drive(1'b1, 1'b1, 1'b0, 32'h0);

    // One-cycle reset in the middle of a stream.
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (8)  drive(1'b1, 1'b1, 1'b0, 32'h0);

    // Randomized traffic: ready throttling, redirects, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, rpc);
    end
    repeat (6) drive(1'b1, 1'b1, 1'b0, 32'h0);

    @(negedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "simulation time limit exceeded");
  end

endmodule
